// File: rtl/text_seg_pkg.sv
// Shared types for the text line segmenter: FSM states, line descriptor
// and default frame geometry. The descriptor fields are sized for the
// default HEIGHT. A larger HEIGHT needs ROW_W widened here.
package text_seg_pkg;

    localparam int DEF_WIDTH  = 1920;
    localparam int DEF_HEIGHT = 1080;
    localparam int ROW_W      = $clog2(DEF_HEIGHT);
    localparam int COL_W      = $clog2(DEF_WIDTH);

    typedef enum logic [1:0] {
        GAP     = 2'd0,
        IN_LINE = 2'd1,
        CLOSING = 2'd2
    } seg_state_t;

    typedef struct packed {
        logic [ROW_W-1:0] top;
        logic [ROW_W-1:0] bottom;
    } line_desc_t;

    // Line height test: bottom - top + 1 >= min_h.
    function automatic logic tall_enough(
        input logic [ROW_W-1:0] top,
        input logic [ROW_W-1:0] bottom,
        input int               min_h
    );
        return (int'(bottom) - int'(top) + 1) >= min_h;
    endfunction

endpackage

// File: rtl/line_desc_fifo.sv
// Synchronous FIFO of line descriptors with full/empty flags.
// Ports: clk, rst_n (sync, active-low), push/wdata, pop/rdata, full, empty.
// A push while full is accepted when a pop happens on the same edge.
// FIFO_DEPTH must be a power of two, at least 2.
module line_desc_fifo
    import text_seg_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  line_desc_t wdata,
    input  logic       pop,
    output line_desc_t rdata,
    output logic       full,
    output logic       empty
);

    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = AW + 1;

    line_desc_t      mem [FIFO_DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [CNTW-1:0] count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CNTW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNTW'(1);
                2'b01:   count <= count - CNTW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

endmodule

// File: rtl/text_line_segmenter.sv
// Streaming text line segmenter: counts ink per row of a binary raster
// frame and emits {top, bottom} descriptors for runs of inked rows.
// Ports: clk, rst_n (sync, active-low); pixel in s_valid/s_ready/s_sof/
// s_pix; descriptor out m_valid/m_ready/m_top/m_bottom; frame_done pulse;
// sticky overflow. Macro TEXT_SEG_PROFILE_EN adds prof_valid/prof_count.
module text_line_segmenter
    import text_seg_pkg::*;
#(
    parameter int   WIDTH      = DEF_WIDTH,
    parameter int   HEIGHT     = DEF_HEIGHT,
    parameter logic INK_VALUE  = 1'b0,
    parameter int   MIN_INK    = 2,
    parameter int   MIN_GAP    = 3,
    parameter int   MIN_HEIGHT = 4,
    parameter int   FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic                        s_sof,
    input  logic                        s_pix,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [$clog2(HEIGHT)-1:0]   m_top,
    output logic [$clog2(HEIGHT)-1:0]   m_bottom,
    output logic                        frame_done,
    output logic                        overflow
`ifdef TEXT_SEG_PROFILE_EN
    ,
    output logic                        prof_valid,
    output logic [$clog2(WIDTH+1)-1:0]  prof_count
`endif
);

    localparam int RW = $clog2(HEIGHT);
    localparam int CW = $clog2(WIDTH);
    localparam int IW = $clog2(WIDTH + 1);
    localparam int GW = $clog2(MIN_GAP + 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [IW-1:0] ink_cnt;

    seg_state_t    state;
    seg_state_t    state_nx;
    logic [RW-1:0] top_r;
    logic [RW-1:0] top_nx;
    logic [RW-1:0] last_r;
    logic [RW-1:0] last_nx;
    logic [GW-1:0] gap_r;
    logic [GW-1:0] gap_nx;

    logic          acc;
    logic [CW-1:0] c_col;
    logic [RW-1:0] c_row;
    logic [IW-1:0] c_ink;
    logic [IW-1:0] ink_nx;
    seg_state_t    c_state;
    logic [GW-1:0] c_gap;
    logic          row_end;
    logic          frame_end;
    logic          row_ink;
    logic          close_line;
    logic          keep;

    logic          push_q;
    line_desc_t    desc_q;
    line_desc_t    head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          drop;

    assign acc = s_valid && s_ready;

    // A start-of-frame pixel is pixel (0,0) of a fresh frame, so the
    // counters and row state it sees are the cleared ones.
    assign c_col   = s_sof ? '0  : col;
    assign c_row   = s_sof ? '0  : row;
    assign c_ink   = s_sof ? '0  : ink_cnt;
    assign c_state = s_sof ? GAP : state;
    assign c_gap   = s_sof ? '0  : gap_r;

    assign ink_nx = ((s_pix == INK_VALUE) && (c_ink != IW'(WIDTH)))
                  ? c_ink + IW'(1) : c_ink;

    assign row_end   = (c_col == CW'(WIDTH - 1));
    assign frame_end = row_end && (c_row == RW'(HEIGHT - 1));
    assign row_ink   = (ink_nx >= IW'(MIN_INK));

    always_comb begin
        state_nx   = state;
        top_nx     = top_r;
        last_nx    = last_r;
        gap_nx     = gap_r;
        close_line = 1'b0;
        keep       = 1'b0;
        if (acc) begin
            state_nx = c_state;
            gap_nx   = c_gap;
            if (row_end) begin
                unique case (c_state)
                    GAP: begin
                        if (row_ink) begin
                            state_nx = IN_LINE;
                            top_nx   = c_row;
                            last_nx  = c_row;
                        end
                    end
                    IN_LINE: begin
                        if (row_ink) begin
                            last_nx = c_row;
                        end else if (MIN_GAP <= 1) begin
                            close_line = 1'b1;
                            state_nx   = GAP;
                        end else begin
                            state_nx = CLOSING;
                            gap_nx   = GW'(1);
                        end
                    end
                    CLOSING: begin
                        if (row_ink) begin
                            state_nx = IN_LINE;
                            last_nx  = c_row;
                            gap_nx   = '0;
                        end else if (int'(c_gap) + 1 >= MIN_GAP) begin
                            close_line = 1'b1;
                            state_nx   = GAP;
                            gap_nx     = '0;
                        end else begin
                            gap_nx = c_gap + GW'(1);
                        end
                    end
                    default: begin
                        state_nx = GAP;
                    end
                endcase
                // A row-driven close always lands in GAP, so the
                // frame-end close below never fires on the same row.
                if (frame_end) begin
                    if (state_nx != GAP) begin
                        close_line = 1'b1;
                    end
                    state_nx = GAP;
                    gap_nx   = '0;
                end
            end
            keep = close_line
                && tall_enough(ROW_W'(top_nx), ROW_W'(last_nx), MIN_HEIGHT);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= GAP;
            top_r  <= '0;
            last_r <= '0;
            gap_r  <= '0;
        end else begin
            state  <= state_nx;
            top_r  <= top_nx;
            last_r <= last_nx;
            gap_r  <= gap_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_ready    <= 1'b0;
            col        <= '0;
            row        <= '0;
            ink_cnt    <= '0;
            frame_done <= 1'b0;
            push_q     <= 1'b0;
            desc_q     <= '0;
            overflow   <= 1'b0;
        end else begin
            s_ready    <= 1'b1;
            frame_done <= acc && frame_end;
            push_q     <= keep;
            if (keep) begin
                desc_q.top    <= ROW_W'(top_nx);
                desc_q.bottom <= ROW_W'(last_nx);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (acc) begin
                if (row_end) begin
                    col     <= '0;
                    ink_cnt <= '0;
                    row     <= frame_end ? '0 : c_row + RW'(1);
                end else begin
                    col     <= c_col + CW'(1);
                    ink_cnt <= ink_nx;
                    row     <= c_row;
                end
            end
        end
    end

    assign m_valid  = !fifo_empty;
    assign pop      = m_valid && m_ready;
    assign drop     = push_q && fifo_full && !pop;
    assign m_top    = m_valid ? RW'(head.top)    : '0;
    assign m_bottom = m_valid ? RW'(head.bottom) : '0;

    line_desc_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_q),
        .wdata (desc_q),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef TEXT_SEG_PROFILE_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prof_valid <= 1'b0;
            prof_count <= '0;
        end else begin
            prof_valid <= acc && row_end;
            if (acc && row_end) begin
                prof_count <= ink_nx;
            end
        end
    end
`endif

endmodule

// File: tb/tb_text_line_segmenter.sv
// Bench for text_line_segmenter: two instances (MIN_GAP=2/depth 4 and
// MIN_GAP=1/depth 2) fed the same random 8x8 frames, checked by a row-list model.
module tb_text_line_segmenter;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int MINK = 2;
    localparam int MH = 2;
    localparam int D1 = 4;
    localparam int D2 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic s_valid = 1'b0;
    logic s_sof = 1'b0;
    logic s_pix = 1'b1;
    logic m_ready1 = 1'b1;
    logic m_ready2 = 1'b1;
    logic s_ready1, s_ready2, m_valid1, m_valid2;
    logic fd1, fd2, ov1, ov2;
    logic [2:0] m_top1, m_bot1, m_top2, m_bot2;

    int total = 0;
    int bad = 0;
    bit frame [H][W];
    int got1[$], got2[$], exp1[$], exp2[$], exp_q[$];
    int fdc1 = 0, fdc2 = 0;
    bit hold1 = 0, hold2 = 0;
    logic [2:0] ht1, hb1, ht2, hb2;

    always #5 clk = ~clk;

    text_line_segmenter #(
        .WIDTH(W), .HEIGHT(H), .INK_VALUE(1'b0), .MIN_INK(MINK),
        .MIN_GAP(2), .MIN_HEIGHT(MH), .FIFO_DEPTH(D1)
    ) dut1 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1),
        .s_sof(s_sof), .s_pix(s_pix), .m_valid(m_valid1),
        .m_ready(m_ready1), .m_top(m_top1), .m_bottom(m_bot1),
        .frame_done(fd1), .overflow(ov1)
    );

    text_line_segmenter #(
        .WIDTH(W), .HEIGHT(H), .INK_VALUE(1'b0), .MIN_INK(MINK),
        .MIN_GAP(1), .MIN_HEIGHT(MH), .FIFO_DEPTH(D2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready2),
        .s_sof(s_sof), .s_pix(s_pix), .m_valid(m_valid2),
        .m_ready(m_ready2), .m_top(m_top2), .m_bottom(m_bot2),
        .frame_done(fd2), .overflow(ov2)
    );

    // Output monitor: collects accepted descriptors, counts frame_done
    // pulses and checks that a stalled descriptor stays put.
    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            hold1 = 0;
            hold2 = 0;
        end else begin
            if (hold1) begin
                total++;
                if (!m_valid1 || m_top1 !== ht1 || m_bot1 !== hb1) begin
                    bad++;
                    $display("FAIL hold dut1 got v=%0b %0d-%0d exp 1 %0d-%0d",
                             m_valid1, m_top1, m_bot1, ht1, hb1);
                end
            end
            if (hold2) begin
                total++;
                if (!m_valid2 || m_top2 !== ht2 || m_bot2 !== hb2) begin
                    bad++;
                    $display("FAIL hold dut2 got v=%0b %0d-%0d exp 1 %0d-%0d",
                             m_valid2, m_top2, m_bot2, ht2, hb2);
                end
            end
            hold1 = m_valid1 && !m_ready1;
            hold2 = m_valid2 && !m_ready2;
            ht1 = m_top1; hb1 = m_bot1;
            ht2 = m_top2; hb2 = m_bot2;
            if (m_valid1 && m_ready1) got1.push_back(int'(m_top1) * 16 + int'(m_bot1));
            if (m_valid2 && m_ready2) got2.push_back(int'(m_top2) * 16 + int'(m_bot2));
            if (fd1) fdc1++;
            if (fd2) fdc2++;
        end
    end

    task automatic clear_frame();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frame[r][c] = 1'b1;
    endtask

    task automatic set_row(input int r, input int n);
        int cnt;
        int c;
        cnt = 0;
        for (int k = 0; k < W; k++) frame[r][k] = 1'b1;
        while (cnt < n) begin
            c = $urandom_range(W - 1, 0);
            if (frame[r][c]) begin
                frame[r][c] = 1'b0;
                cnt++;
            end
        end
    endtask

    // Reference: list the ink rows, split wherever the blank run between
    // consecutive ink rows reaches mg, keep segments of height >= MH.
    task automatic model(input int mg);
        int rows[$];
        int n, t, b;
        exp_q.delete();
        for (int r = 0; r < H; r++) begin
            n = 0;
            for (int c = 0; c < W; c++) if (frame[r][c] == 1'b0) n++;
            if (n >= MINK) rows.push_back(r);
        end
        if (rows.size() > 0) begin
            t = rows[0];
            b = rows[0];
            for (int i = 1; i < rows.size(); i++) begin
                if (rows[i] - b - 1 >= mg) begin
                    if (b - t + 1 >= MH) exp_q.push_back(t * 16 + b);
                    t = rows[i];
                end
                b = rows[i];
            end
            if (b - t + 1 >= MH) exp_q.push_back(t * 16 + b);
        end
    endtask

    task automatic build_exp();
        model(2);
        exp1 = exp_q;
        model(1);
        exp2 = exp_q;
    endtask

    task automatic clear_obs();
        got1.delete();
        got2.delete();
        fdc1 = 0;
        fdc2 = 0;
    endtask

    task automatic send_frame(input int npix, input bit rnd);
        for (int i = 0; i < npix; i++) begin
            if (rnd) begin
                while ($urandom_range(3, 0) == 0) begin
                    @(negedge clk);
                    s_valid = 1'b0;
                end
            end
            @(negedge clk);
            s_valid = 1'b1;
            s_sof = (i == 0);
            s_pix = frame[i / W][i % W];
            if (rnd) begin
                m_ready1 = 1'($urandom_range(1, 0));
                m_ready2 = 1'($urandom_range(1, 0));
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_sof = 1'b0;
        s_pix = 1'b1;
        if (rnd) begin
            m_ready1 = 1'b1;
            m_ready2 = 1'b1;
        end
        if (npix == W * H) begin
            total++;
            if (fd1 !== 1'b1 || fd2 !== 1'b1) begin
                bad++;
                $display("FAIL frame_done_edge got %0b/%0b exp 1/1", fd1, fd2);
            end
            @(negedge clk);
            total++;
            if (fd1 !== 1'b0 || fd2 !== 1'b0) begin
                bad++;
                $display("FAIL frame_done_pulse got %0b/%0b exp 0/0", fd1, fd2);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (s_ready1 !== 1'b0 || m_valid1 !== 1'b0 || fd1 !== 1'b0 ||
            ov1 !== 1'b0 || m_top1 !== 3'd0 || m_bot1 !== 3'd0) begin
            bad++;
            $display("FAIL reset dut1 got rdy=%0b v=%0b fd=%0b ov=%0b t=%0d b=%0d exp all 0",
                     s_ready1, m_valid1, fd1, ov1, m_top1, m_bot1);
        end
        total++;
        if (s_ready2 !== 1'b0 || m_valid2 !== 1'b0 || fd2 !== 1'b0 ||
            ov2 !== 1'b0 || m_top2 !== 3'd0 || m_bot2 !== 3'd0) begin
            bad++;
            $display("FAIL reset dut2 got rdy=%0b v=%0b fd=%0b ov=%0b t=%0d b=%0d exp all 0",
                     s_ready2, m_valid2, fd2, ov2, m_top2, m_bot2);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (s_ready1 !== 1'b1 || s_ready2 !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_reset got %0b/%0b exp 1/1", s_ready1, s_ready2);
        end
        clear_obs();
    endtask

    task automatic test_all_blank();
        clear_obs();
        clear_frame();
        build_exp();
        send_frame(W * H, 1'b0);
        repeat (10) @(negedge clk);
        total++;
        if (got1.size() !== 0 || got2.size() !== 0) begin
            bad++;
            $display("FAIL all_blank descs got %0d/%0d exp 0/0", got1.size(), got2.size());
        end
        total++;
        if (fdc1 !== 1 || fdc2 !== 1) begin
            bad++;
            $display("FAIL all_blank fd_count got %0d/%0d exp 1/1", fdc1, fdc2);
        end
    endtask

    task automatic compare_run(input string name);
        total++;
        if (got1.size() !== exp1.size()) begin
            bad++;
            $display("FAIL %s dut1 count got %0d exp %0d", name, got1.size(), exp1.size());
        end else begin
            foreach (exp1[i]) begin
                total++;
                if (got1[i] !== exp1[i]) begin
                    bad++;
                    $display("FAIL %s dut1 desc%0d got %0h exp %0h", name, i, got1[i], exp1[i]);
                end
            end
        end
        total++;
        if (got2.size() !== exp2.size()) begin
            bad++;
            $display("FAIL %s dut2 count got %0d exp %0d", name, got2.size(), exp2.size());
        end else begin
            foreach (exp2[i]) begin
                total++;
                if (got2[i] !== exp2[i]) begin
                    bad++;
                    $display("FAIL %s dut2 desc%0d got %0h exp %0h", name, i, got2[i], exp2[i]);
                end
            end
        end
    endtask

    task automatic test_single_line();
        clear_obs();
        clear_frame();
        for (int r = 2; r <= 5; r++) set_row(r, 3);
        build_exp();
        send_frame(W * H, 1'b1);
        repeat (10) @(negedge clk);
        compare_run("single_line");
    endtask

    task automatic test_gap_merge();
        clear_obs();
        clear_frame();
        set_row(1, $urandom_range(W, 2));
        set_row(2, $urandom_range(W, 2));
        set_row(3, 1);
        set_row(4, $urandom_range(W, 2));
        set_row(5, $urandom_range(W, 2));
        build_exp();
        send_frame(W * H, 1'b1);
        repeat (10) @(negedge clk);
        compare_run("gap_merge");
    endtask

    task automatic test_short_discard();
        clear_obs();
        clear_frame();
        set_row(0, 3);
        set_row(6, 3);
        set_row(7, 3);
        build_exp();
        send_frame(W * H, 1'b0);
        repeat (10) @(negedge clk);
        compare_run("short_discard");
    endtask

    task automatic test_overflow();
        clear_obs();
        clear_frame();
        foreach (exp_q[i]) exp_q[i] = 0;
        set_row(0, 3); set_row(1, 3);
        set_row(3, 3); set_row(4, 3);
        set_row(6, 3); set_row(7, 3);
        build_exp();
        @(negedge clk);
        m_ready1 = 1'b0;
        m_ready2 = 1'b0;
        send_frame(W * H, 1'b0);
        repeat (6) @(negedge clk);
        total++;
        if (ov2 !== 1'(exp2.size() > D2) || ov1 !== 1'(exp1.size() > D1)) begin
            bad++;
            $display("FAIL overflow_flag got %0b/%0b exp %0b/%0b",
                     ov1, ov2, exp1.size() > D1, exp2.size() > D2);
        end
        total++;
        if (m_valid2 !== 1'b1 || int'(m_top2) * 16 + int'(m_bot2) !== exp2[0]) begin
            bad++;
            $display("FAIL overflow_head dut2 got v=%0b %0d-%0d exp %0h",
                     m_valid2, m_top2, m_bot2, exp2[0]);
        end
        while (exp1.size() > D1) void'(exp1.pop_back());
        while (exp2.size() > D2) void'(exp2.pop_back());
        m_ready1 = 1'b1;
        m_ready2 = 1'b1;
        repeat (10) @(negedge clk);
        compare_run("overflow_drain");
    endtask

    task automatic test_reset_mid();
        clear_frame();
        for (int r = 2; r <= 4; r++) set_row(r, 4);
        send_frame(4 * W + 4, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (ov2 !== 1'b0 || m_valid1 !== 1'b0 || m_valid2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid clear got ov2=%0b v=%0b/%0b exp 0 0/0",
                     ov2, m_valid1, m_valid2);
        end
        rst_n = 1'b1;
        clear_obs();
        clear_frame();
        set_row(2, 3);
        set_row(3, 3);
        build_exp();
        send_frame(W * H, 1'b1);
        repeat (10) @(negedge clk);
        compare_run("reset_mid");
        total++;
        if (ov1 !== 1'b0 || ov2 !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid overflow got %0b/%0b exp 0/0", ov1, ov2);
        end
    endtask

    task automatic test_sof_restart();
        clear_obs();
        clear_frame();
        set_row(1, 5);
        set_row(2, 5);
        send_frame(3 * W, 1'b0);
        clear_frame();
        set_row(5, 3);
        set_row(6, 4);
        build_exp();
        send_frame(W * H, 1'b0);
        repeat (10) @(negedge clk);
        compare_run("sof_restart");
        total++;
        if (fdc1 !== 1 || fdc2 !== 1) begin
            bad++;
            $display("FAIL sof_restart fd_count got %0d/%0d exp 1/1", fdc1, fdc2);
        end
    endtask

    task automatic test_back_to_back();
        int sel;
        clear_obs();
        clear_frame();
        for (int r = 0; r < H; r++) begin
            sel = $urandom_range(3, 0);
            set_row(r, (sel == 0) ? 0 : (sel == 1) ? 1 : $urandom_range(W, 2));
        end
        build_exp();
        exp1 = {exp1, exp1};
        exp2 = {exp2, exp2};
        // Second frame carries no s_sof; the counters wrap on their own.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < W * H; i++) begin
                @(negedge clk);
                s_valid = 1'b1;
                s_sof = (k == 0 && i == 0);
                s_pix = frame[i / W][i % W];
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_sof = 1'b0;
        repeat (10) @(negedge clk);
        compare_run("back_to_back");
        total++;
        if (fdc1 !== 2 || fdc2 !== 2) begin
            bad++;
            $display("FAIL back_to_back fd_count got %0d/%0d exp 2/2", fdc1, fdc2);
        end
    endtask

    task automatic test_random();
        int sel;
        for (int f = 0; f < 8; f++) begin
            clear_obs();
            clear_frame();
            for (int r = 0; r < H; r++) begin
                sel = $urandom_range(3, 0);
                set_row(r, (sel == 0) ? 0 : (sel == 1) ? 1 : $urandom_range(W, 2));
            end
            build_exp();
            send_frame(W * H, 1'b1);
            repeat (10) @(negedge clk);
            compare_run("random");
        end
        total++;
        if (ov1 !== 1'b0 || ov2 !== 1'b0) begin
            bad++;
            $display("FAIL random overflow got %0b/%0b exp 0/0", ov1, ov2);
        end
    endtask

    initial begin
        test_reset();
        test_all_blank();
        test_single_line();
        test_gap_merge();
        test_short_discard();
        test_sof_restart();
        test_back_to_back();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
